dmem_responder: RTL and testbench

//  Data-memory responder (target side) for RV32I load/store traffic from the core's LSU.

---
 rtl/dmem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for RV32I LSU traffic: one request at a time, byte-lane
// store merging, size-extracted loads, programmable wait states, fault reporting.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the sender keeps valid and its payload stable until that edge, ready never waits on valid.
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } acc_size_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       commit;

  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr, lat_wdata;

  logic        cur_we;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr, cur_wdata;

  acc_size_t        cur_size;
  logic             cur_signed;
  logic [IDX_W-1:0] cur_idx;
  logic [1:0]       cur_lane;
  logic             range_err, align_err, access_err;

  logic [3:0]  byte_en;
  logic [31:0] wdata_lanes;
  logic [31:0] rd_word, load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_next   = '0;
          state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) state_next = RESP;
        else                 cnt_next   = cnt + 4'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The edge entering RESP is the commit point; reset on that edge cancels it.
  assign commit = rst_n && (state_next == RESP) && (state != RESP);

  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      lat_we     <= req_we;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end
  end

  // With no wait states the commit edge is the accept edge, so decode the live request.
  assign cur_we     = (state == IDLE) ? req_we     : lat_we;
  assign cur_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
  assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;

  always_comb begin
    cur_size   = SZ_ILL;
    cur_signed = 1'b0;
    if (cur_we) begin
      case (cur_funct3)
        3'b000:  cur_size = SZ_BYTE;
        3'b001:  cur_size = SZ_HALF;
        3'b010:  cur_size = SZ_WORD;
        default: cur_size = SZ_ILL;
      endcase
    end else begin
      case (cur_funct3)
        3'b000: begin cur_size = SZ_BYTE; cur_signed = 1'b1; end
        3'b001: begin cur_size = SZ_HALF; cur_signed = 1'b1; end
        3'b010: cur_size = SZ_WORD;
        3'b011: cur_size = SZ_BYTE;
        3'b100: cur_size = SZ_HALF;
        default: cur_size = SZ_ILL;
      endcase
    end
  end

  assign cur_idx   = cur_addr[IDX_W+1:2];
  assign cur_lane  = cur_addr[1:0];
  assign range_err = (cur_addr >> (IDX_W + 2)) != 32'd0;

  always_comb begin
    align_err = 1'b0;
    case (cur_size)
      SZ_HALF: align_err = cur_addr[0];
      SZ_WORD: align_err = |cur_addr[1:0];
      default: align_err = 1'b0;
    endcase
  end

  assign access_err = range_err || align_err || (cur_size == SZ_ILL);

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = '0;
    case (cur_size)
      SZ_BYTE: begin
        byte_en     = 4'b0001 << cur_lane;
        wdata_lanes = {4{cur_wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{cur_wdata[15:0]}};
      end
      SZ_WORD: begin
        byte_en     = 4'b1111;
        wdata_lanes = cur_wdata;
      end
      default: begin
        byte_en     = 4'b0000;
        wdata_lanes = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && cur_we && !access_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[cur_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  assign rd_word = mem[cur_idx];

  always_comb begin
    byte_sel = rd_word[{cur_lane, 3'b000} +: 8];
    half_sel = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = '0;
    case (cur_size)
      SZ_BYTE: load_val = cur_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      SZ_HALF: load_val = cur_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      SZ_WORD: load_val = rd_word;
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q   <= access_err;
      rdata_q <= (access_err || cur_we) ? 32'd0 : load_val;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (3 and 0 wait states) driven by directed and
// random traffic, checked against a byte-addressed reference memory.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic [1:0]  rst_n, req_valid, req_we, rsp_ready;
  logic [1:0]  req_ready, rsp_valid, rsp_err;
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] rsp_rdata  [2];

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];
  logic [7:0]  model_mem [longint];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int wait_of(input int idx);
    return (idx == 0) ? 3 : 0;
  endfunction

  function automatic int depth_of(input int idx);
    return (idx == 0) ? 1024 : 16;
  endfunction

  // Reference: memory as individual bytes; returns {err, rdata}.
  function automatic logic [32:0] model_access(input int idx, input logic we,
      input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int     nbytes = 0;
    bit     sgn    = 0;
    longint base, val, span;
    if (we) begin
      case (f3)
        3'd0: nbytes = 1;
        3'd1: nbytes = 2;
        3'd2: nbytes = 4;
        default: nbytes = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin nbytes = 1; sgn = 1; end
        3'd1: begin nbytes = 2; sgn = 1; end
        3'd2: nbytes = 4;
        3'd3: nbytes = 1;
        3'd4: nbytes = 2;
        default: nbytes = 0;
      endcase
    end
    if (nbytes == 0) return {1'b1, 32'd0};
    if (longint'(addr) >= longint'(depth_of(idx)) * 4) return {1'b1, 32'd0};
    if ((longint'(addr) % nbytes) != 0) return {1'b1, 32'd0};
    base = (longint'(idx) << 32) + longint'(addr);
    if (we) begin
      for (int i = 0; i < nbytes; i++) model_mem[base + i] = wdata[8*i +: 8];
      return 33'd0;
    end
    val = 0;
    for (int i = 0; i < nbytes; i++) val += longint'(model_mem[base + i]) << (8 * i);
    span = longint'(1) << (8 * nbytes);
    if (sgn && val >= span / 2) val -= span;
    return {1'b0, 32'(val)};
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input int idx, input logic we, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] wdata);
    int guard = 0;
    req_we[idx] = we;
    req_funct3[idx] = f3;
    req_addr[idx] = addr;
    req_wdata[idx] = wdata;
    req_valid[idx] = 1'b1;
    while (!req_ready[idx] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_in_time", 33'(guard < 100), 33'd1);
    exp_q.push_back(model_access(idx, we, f3, addr, wdata));
    @(negedge clk);
    req_valid[idx] = 1'b0;
  endtask

  task automatic receive(input int idx, input int hold);
    int          lat = 1;
    logic [32:0] got, exp;
    while (!rsp_valid[idx] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", 33'(lat), 33'(wait_of(idx) + 1));
    got = {rsp_err[idx], rsp_rdata[idx]};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 33'(rsp_valid[idx]), 33'd1);
      check("hold_rsp_data", {rsp_err[idx], rsp_rdata[idx]}, got);
      check("hold_req_ready", 33'(req_ready[idx]), 33'd0);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_dead_dead;
    check("rsp_err_rdata", got, exp);
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
    check("rsp_valid_drop", 33'(rsp_valid[idx]), 33'd0);
  endtask

  task automatic gen(input int idx, input logic [31:0] base);
    logic [31:0] a;
    a = base + 32'($urandom_range(0, 31));
    if ($urandom_range(0, 7) == 0) a = a + 32'(depth_of(idx) * 4);
    req_we[idx]     = 1'($urandom_range(0, 1));
    req_funct3[idx] = 3'($urandom_range(0, 7));
    req_addr[idx]   = a;
    req_wdata[idx]  = $urandom();
  endtask

  task automatic run_b2b(input int idx, input int n, input logic [31:0] base);
    int cyc = 0, last = -1, accepted = 0;
    gen(idx, base);
    req_valid[idx] = 1'b1;
    rsp_ready[idx] = 1'b1;
    while ((accepted < n || exp_q.size() > 0) && cyc < 2000) begin
      if (rsp_valid[idx]) begin
        check("b2b_rsp", {rsp_err[idx], rsp_rdata[idx]},
              (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_dead_dead);
      end
      if (req_valid[idx] && req_ready[idx]) begin
        exp_q.push_back(model_access(idx, req_we[idx], req_funct3[idx], req_addr[idx],
                                     req_wdata[idx]));
        if (last >= 0) check("b2b_accept_gap", 33'(cyc - last), 33'(wait_of(idx) + 2));
        last = cyc;
        accepted++;
        @(negedge clk);
        cyc++;
        if (accepted < n) gen(idx, base);
        else req_valid[idx] = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("b2b_accepted", 33'(accepted), 33'(n));
    req_valid[idx] = 1'b0;
    rsp_ready[idx] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 2'b00;
    req_valid = 2'b00;
    req_we = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_funct3[i] = '0;
      req_addr[i] = '0;
      req_wdata[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_rsp_valid", 33'(rsp_valid[i]), 33'd0);
      check("reset_rsp_out", {rsp_err[i], rsp_rdata[i]}, 33'd0);
    end
    rst_n = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("reset_req_ready", 33'(req_ready[i]), 33'd1);

    // Word store then load
    send(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF); receive(0, 0);
    send(0, 1'b0, 3'd2, 32'h10, 32'h0);        receive(0, 0);

    // Byte-lane merge and extraction
    send(0, 1'b1, 3'd2, 32'h20, 32'h11223344); receive(0, 0);
    send(0, 1'b1, 3'd0, 32'h21, 32'h000000AA); receive(0, 0);
    send(0, 1'b1, 3'd1, 32'h22, 32'h00008001); receive(0, 0);
    send(0, 1'b0, 3'd2, 32'h20, 32'h0); receive(0, 0);
    send(0, 1'b0, 3'd0, 32'h21, 32'h0); receive(0, 0);
    send(0, 1'b0, 3'd3, 32'h21, 32'h0); receive(0, 0);
    send(0, 1'b0, 3'd1, 32'h22, 32'h0); receive(0, 0);
    send(0, 1'b0, 3'd4, 32'h22, 32'h0); receive(0, 0);

    // Faulting accesses leave memory untouched
    send(0, 1'b1, 3'd2, 32'h0, 32'h5A5A1234); receive(0, 0);
    send(0, 1'b0, 3'd2, 32'h22, 32'h0);       receive(0, 0);
    send(0, 1'b1, 3'd1, 32'h23, 32'h0000FFFF); receive(0, 0);
    send(0, 1'b0, 3'd5, 32'h20, 32'h0);       receive(0, 0);
    send(0, 1'b1, 3'd2, 32'h1000, 32'hFFFFFFFF); receive(0, 0);
    send(0, 1'b1, 3'd3, 32'h20, 32'hFFFFFFFF); receive(0, 0);
    send(0, 1'b0, 3'd2, 32'h20, 32'h0); receive(0, 0);
    send(0, 1'b0, 3'd2, 32'h0, 32'h0);  receive(0, 0);

    // Stalled response with a competing request pending
    send(0, 1'b0, 3'd2, 32'h10, 32'h0);
    req_we[0] = 1'b0; req_funct3[0] = 3'd2; req_addr[0] = 32'h20; req_valid[0] = 1'b1;
    receive(0, 5);
    send(0, 1'b0, 3'd2, 32'h20, 32'h0); receive(0, 0);

    // Reset during WAIT drops an uncommitted store
    send(0, 1'b1, 3'd2, 32'h30, 32'h1234ABCD); receive(0, 0);
    req_we[0] = 1'b1; req_funct3[0] = 3'd2; req_addr[0] = 32'h30;
    req_wdata[0] = 32'hCAFEF00D; req_valid[0] = 1'b1;
    check("abort_accept_ready", 33'(req_ready[0]), 33'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    check("abort_rsp_valid", 33'(rsp_valid[0]), 33'd0);
    check("abort_req_ready", 33'(req_ready[0]), 33'd1);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_rsp", 33'(rsp_valid[0]), 33'd0);
    end
    send(0, 1'b0, 3'd2, 32'h30, 32'h0); receive(0, 0);

    // Random single transactions against a pre-initialised word pool
    for (int i = 0; i < 8; i++) begin
      send(0, 1'b1, 3'd2, 32'h100 + 32'(4 * i), $urandom()); receive(0, 0);
      send(1, 1'b1, 3'd2, 32'(4 * i), $urandom()); receive(1, 0);
    end
    for (int i = 0; i < 40; i++) begin
      gen(0, 32'h100);
      send(0, req_we[0], req_funct3[0], req_addr[0], req_wdata[0]);
      receive(0, $urandom_range(0, 2));
    end

    // Back-to-back traffic with valid and ready held high
    run_b2b(1, 30, 32'h0);
    run_b2b(0, 20, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
